// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB master arbiter codebase slice.
//   apb_state_e     : APB master sequencer states (IDLE, SETUP, ACCESS)
//   APB_ADDR_WIDTH  : default APB address width
//   APB_DATA_WIDTH  : default APB data width
// ---------------------------------------------------------------------------
package apb_pkg;

   localparam int APB_ADDR_WIDTH = 10;
   localparam int APB_DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } apb_state_e;

endpackage : apb_pkg

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. The search for a winner starts at
// index ptr and wraps around, so the requester at ptr has highest priority.
// Ports:
//   req   in  NUM_REQ  request vector
//   ptr   in  IDX_W    index where the priority search starts (< NUM_REQ)
//   grant out NUM_REQ  one-hot grant (zero when no request)
//   index out IDX_W    index of the granted requester
//   valid out 1        at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   index,
   output logic               valid
);

   logic [IDX_W-1:0] cand;

   // NOTE: every output of a combinational block gets a default before any
   // conditional assignment; a path that leaves one unassigned infers a latch.
   always_comb begin
      grant = '0;
      index = '0;
      valid = 1'b0;
      cand  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
         if (!valid && req[cand]) begin
            grant[cand] = 1'b1;
            index       = cand;
            valid       = 1'b1;
         end
      end
   end

endmodule : rr_arbiter

// File: rtl/apb_master_arbiter.sv
// ---------------------------------------------------------------------------
// apb_master_arbiter
// APB master sharing one APB slave port between NUM_REQ local requesters.
// Requesters are served round-robin; each transfer runs SETUP then ACCESS
// (waiting on PREADY) and ends with a one-cycle done_o pulse to the winner.
// Optional feature: define APB_TIMEOUT_EN to abort an ACCESS phase after
// TIMEOUT_CYCLES wait cycles (done_o with err_o=1). Without it err_o is 0.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   req_i / req_write_i      per-requester valid / write flag
//   req_addr_i / req_wdata_i packed per-requester address / write data
//   done_o, err_o, rdata_o   completion pulse, abort flag, read data
//   psel_o, penable_o, paddr_o, pwrite_o, pwdata_o  APB request side
//   prdata_i, pready_i       APB response side
// ---------------------------------------------------------------------------
module apb_master_arbiter
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
   parameter int DATA_WIDTH     = APB_DATA_WIDTH,
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             req_i,
   input  logic [NUM_REQ-1:0]             req_write_i,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata_i,
   output logic [NUM_REQ-1:0]             done_o,
   output logic                           err_o,
   output logic [DATA_WIDTH-1:0]          rdata_o,
   output logic                           psel_o,
   output logic                           penable_o,
   output logic [ADDR_WIDTH-1:0]          paddr_o,
   output logic                           pwrite_o,
   output logic [DATA_WIDTH-1:0]          pwdata_o,
   input  logic [DATA_WIDTH-1:0]          prdata_i,
   input  logic                           pready_i
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   if (NUM_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_param_guard
      $error("apb_master_arbiter: NUM_REQ must be >= 2 and TIMEOUT_CYCLES >= 1");
   end

   apb_state_e        state;
   logic [IDX_W-1:0]  ptr;
   logic [IDX_W-1:0]  winner;
   logic [NUM_REQ-1:0] winner_oh;

   logic [NUM_REQ-1:0]    eligible;
   logic [NUM_REQ-1:0]    arb_grant;
   logic [IDX_W-1:0]      arb_idx;
   logic                  arb_valid;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic                  sel_write;
   logic [IDX_W-1:0]      ptr_next;

   // A requester whose done_o is pulsing may still show req_i this cycle;
   // masking it keeps a late-dropped request from being granted twice.
   assign eligible = req_i & ~done_o;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_arbiter (
      .req   (eligible),
      .ptr   (ptr),
      .grant (arb_grant),
      .index (arb_idx),
      .valid (arb_valid)
   );

   assign sel_addr  = req_addr_i[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
   assign sel_wdata = req_wdata_i[arb_idx*DATA_WIDTH +: DATA_WIDTH];
   assign sel_write = req_write_i[arb_idx];
   assign ptr_next  = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

`ifdef APB_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] tmo_cnt;
`else
   // Without the timeout the ACCESS phase waits on PREADY indefinitely.
   assign err_o = 1'b0;
`endif

   // NOTE: state and outputs are registered with non-blocking assignments so
   // every read in this block sees the value from before the clock edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         ptr       <= '0;
         winner    <= '0;
         winner_oh <= '0;
         psel_o    <= 1'b0;
         penable_o <= 1'b0;
         pwrite_o  <= 1'b0;
         paddr_o   <= '0;
         pwdata_o  <= '0;
         rdata_o   <= '0;
         done_o    <= '0;
`ifdef APB_TIMEOUT_EN
         err_o     <= 1'b0;
         tmo_cnt   <= '0;
`endif
      end else begin
         done_o <= '0;
`ifdef APB_TIMEOUT_EN
         err_o  <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (arb_valid) begin
                  winner    <= arb_idx;
                  winner_oh <= arb_grant;
                  paddr_o   <= sel_addr;
                  pwrite_o  <= sel_write;
                  pwdata_o  <= sel_write ? sel_wdata : '0;
                  psel_o    <= 1'b1;
                  state     <= SETUP;
               end
            end
            SETUP: begin
               penable_o <= 1'b1;
`ifdef APB_TIMEOUT_EN
               tmo_cnt   <= '0;
`endif
               state     <= ACCESS;
            end
            ACCESS: begin
               if (pready_i) begin
                  if (!pwrite_o) begin
                     rdata_o <= prdata_i;
                  end
                  psel_o    <= 1'b0;
                  penable_o <= 1'b0;
                  done_o    <= winner_oh;
                  ptr       <= ptr_next;
                  state     <= IDLE;
               end
`ifdef APB_TIMEOUT_EN
               else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
                  // This wait cycle brings the count to TIMEOUT_CYCLES.
                  if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                     psel_o    <= 1'b0;
                     penable_o <= 1'b0;
                     done_o    <= winner_oh;
                     err_o     <= 1'b1;
                     ptr       <= ptr_next;
                     state     <= IDLE;
                  end
               end
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule : apb_master_arbiter

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- APB master that shares one APB slave port (the memory-backed APB slave) between NUM_REQ local requesters.
- Each requester posts a single read or write command; the block arbitrates round-robin, drives the SETUP/ACCESS sequence and waits on PREADY.
- It returns a one-cycle completion pulse with read data to the granted requester.

Parameters:
- ADDR_WIDTH, 10, APB/requester address width
- DATA_WIDTH, 32, APB/requester data width
- NUM_REQ, 2, number of requesters (>=2)
- TIMEOUT_CYCLES, 16, max ACCESS cycles before abort (used only with APB_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_i  in  NUM_REQ  per-requester command valid; held until matching done_o
- req_write_i  in  NUM_REQ  1=write, 0=read
- req_addr_i  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester n at [n*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata_i  in  NUM_REQ*DATA_WIDTH  packed write data
- done_o  out  NUM_REQ  one-cycle completion pulse, one-hot or zero
- err_o  out  1  valid with done_o; 1=transfer aborted
- rdata_o  out  DATA_WIDTH  read data, valid with done_o on reads
- psel_o  out  1  APB PSEL
- penable_o  out  1  APB PENABLE
- paddr_o  out  ADDR_WIDTH  APB PADDR
- pwrite_o  out  1  APB PWRITE
- pwdata_o  out  DATA_WIDTH  APB PWDATA
- prdata_i  in  DATA_WIDTH  APB PRDATA
- pready_i  in  1  APB PREADY

Behaviour:
- Clocking and reset:
  - Single clock domain; reset is synchronous and active-high.
  - Reset values: psel_o, penable_o, pwrite_o, done_o, err_o = 0; paddr_o, pwdata_o, rdata_o = 0; state = IDLE; rr pointer = 0.
- FSM states IDLE, SETUP, ACCESS:
  - IDLE: compute the eligible vector = req_i & ~done_o. If nonzero, pick the winner round-robin, starting from index ptr. Register winner index, paddr_o, pwrite_o and pwdata_o (pwdata_o = 0 for reads). Go to SETUP.
  - SETUP: psel_o=1, penable_o=0. Go to ACCESS unconditionally.
  - ACCESS: psel_o=1, penable_o=1. Stay while pready_i=0. On pready_i=1:
    - capture prdata_i into rdata_o if read;
    - next cycle done_o[winner]=1, err_o=0;
    - psel_o and penable_o drop to 0;
    - state IDLE; ptr = (winner+1) mod NUM_REQ.
- Timing:
  - Minimum transfer: req seen in IDLE at cycle T, SETUP at T+1, ACCESS at T+2. If pready_i=1 at T+2, done_o at T+3.
  - Each PREADY wait cycle adds one cycle.
- Address/data stability: paddr_o, pwrite_o and pwdata_o stay constant from SETUP through the last ACCESS cycle. Requester inputs are sampled only in IDLE.
- No back-to-back transfers: at least one IDLE cycle between transfers. That IDLE cycle coincides with the done_o pulse.
- Masking: a requester pulsing done_o is masked in that IDLE cycle, so a late-dropped req is not re-granted. A different pending requester may be granted in that same cycle.
- Dropping req: deasserting req_i after grant has no effect; the transfer completes and done_o still pulses.
- rdata_o: holds its last value between reads; it is unchanged on writes.
- Reset mid-transfer: immediate return to reset values. No done_o is issued for the aborted transfer. psel_o is 0 in the cycle after reset is sampled.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,NUM_REQ-1,0...

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A counter clears on SETUP and increments on each ACCESS cycle with pready_i=0.
  - When it reaches TIMEOUT_CYCLES, the transfer aborts: psel_o and penable_o drop, and next cycle done_o[winner]=1 with err_o=1. rdata_o is unchanged.
  - FSM returns to IDLE and ptr advances as normal.
- Undefined:
  - No counter; ACCESS waits indefinitely.
  - err_o is tied to 0.

Decomposition:
- Package apb_pkg:
  - typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e
  - default ADDR_WIDTH/DATA_WIDTH localparams
- Sub-module rr_arbiter (NUM_REQ):
  - inputs: request vector, pointer
  - output: one-hot grant plus index
  - purely combinational, reusable by other shared-resource controllers
- The FSM, datapath registers and timeout stay in apb_master_arbiter.

Test Plan:
- Single write: req_i=01, addr 0x10, wdata 0xDEADBEEF, slave with 1 wait state -> psel rises at T+1, penable at T+2, done_o=01 at T+4, memory[0x10]=0xDEADBEEF.
- Single read: read back 0x10 from requester 1 -> done_o=10, err_o=0, rdata_o=0xDEADBEEF.
- Contention: both request at the same cycle after reset (r0 writes 0x20=0xF00DF00D, r1 reads 0x20) -> r0 served first; r1 then reads 0xF00DF00D. Both held continuously for 4 transfers -> grant order 0,1,0,1.
- Late req drop: requester holds req_i one cycle past done_o while the other is idle -> no regrant; psel_o stays 0.
- Reset in ACCESS: assert reset while penable_o=1 and pready_i=0 -> next cycle psel_o=penable_o=done_o=0 and state IDLE; a later transfer works.
- APB_TIMEOUT_EN with TIMEOUT_CYCLES=16: pready_i held 0 -> done_o pulse with err_o=1 after 16 ACCESS cycles; rdata_o unchanged. Without the macro, no done_o is issued after 100 cycles.
